// File: rtl/stl_lut_table.sv
// Small associative key/data table with write/update, clear-all walk and
// single-cycle registered lookup; contents are also exported as a packed LUT bus.
module stl_lut_table #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_wr_valid,
    input  logic [KEY_LEN-1:0]                   i_wr_key,
    input  logic [DATA_LEN-1:0]                  i_wr_data,
    output logic                                 o_wr_ready,
    output logic                                 o_wr_done,
    output logic                                 o_wr_err,
    input  logic                                 i_clr,
    input  logic                                 i_rd_valid,
    input  logic [KEY_LEN-1:0]                   i_rd_key,
    output logic                                 o_rd_valid,
    output logic                                 o_rd_hit,
    output logic [DATA_LEN-1:0]                  o_rd_data,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] o_lut,
    output logic [NR_KEY-1:0]                    o_vld_mask,
    output logic [$clog2(NR_KEY+1)-1:0]          o_count
);

    localparam int ENT_W = KEY_LEN + DATA_LEN;
    localparam int IDX_W = $clog2(NR_KEY);
    localparam int CNT_W = $clog2(NR_KEY + 1);

    typedef enum logic [0:0] {IDLE, CLR} state_t;

    state_t              state_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [NR_KEY-1:0]   vld_q;
    logic [CNT_W-1:0]    count_q;
    logic [IDX_W-1:0]    clrIdx_q;
    logic                wrDone_q;
    logic                wrErr_q;
    logic                rdValid_q;
    logic                rdHit_q;
    logic [DATA_LEN-1:0] rdData_q;

    logic                wrHit;
    logic [IDX_W-1:0]    wrHitIdx;
    logic                freeFound;
    logic [IDX_W-1:0]    freeIdx;
    logic                rdHit;
    logic [DATA_LEN-1:0] rdData;
    logic                wrAccept;
    logic                tableFull;

    // Only valid entries take part in matching; free slot search favours the lowest index.
    always_comb begin
        wrHit     = 1'b0;
        wrHitIdx  = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        rdHit     = 1'b0;
        rdData    = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (vld_q[i] && key_q[i] == i_wr_key) begin
                wrHit    = 1'b1;
                wrHitIdx = IDX_W'(i);
            end
            if (!vld_q[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (vld_q[i] && key_q[i] == i_rd_key) begin
                rdHit  = 1'b1;
                rdData = data_q[i];
            end
        end
    end

    assign o_wr_ready = (state_q == IDLE) && !i_clr;
    assign wrAccept   = i_wr_valid && o_wr_ready;
    assign tableFull  = (count_q == CNT_W'(NR_KEY));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
            vld_q     <= '0;
            count_q   <= '0;
            clrIdx_q  <= '0;
            wrDone_q  <= 1'b0;
            wrErr_q   <= 1'b0;
            rdValid_q <= 1'b0;
            rdHit_q   <= 1'b0;
            rdData_q  <= '0;
        end else begin
            wrDone_q  <= wrAccept;
            wrErr_q   <= 1'b0;
            rdValid_q <= i_rd_valid;
            // Lookups see pre-write contents and always miss during the clear walk.
            rdHit_q   <= i_rd_valid && (state_q == IDLE) && rdHit;
            rdData_q  <= (i_rd_valid && (state_q == IDLE) && rdHit) ? rdData : '0;
            case (state_q)
                IDLE: begin
                    if (i_clr) begin
                        state_q  <= CLR;
                        clrIdx_q <= '0;
                    end else if (wrAccept) begin
                        if (wrHit) begin
                            data_q[wrHitIdx] <= i_wr_data;
                        end else if (!tableFull) begin
                            key_q[freeIdx]  <= i_wr_key;
                            data_q[freeIdx] <= i_wr_data;
                            vld_q[freeIdx]  <= 1'b1;
                            count_q         <= count_q + CNT_W'(1);
                        end else begin
                            wrErr_q <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    key_q[clrIdx_q]  <= '0;
                    data_q[clrIdx_q] <= '0;
                    vld_q[clrIdx_q]  <= 1'b0;
                    if (vld_q[clrIdx_q]) begin
                        count_q <= count_q - CNT_W'(1);
                    end
                    if (clrIdx_q == IDX_W'(NR_KEY - 1)) begin
                        state_q  <= IDLE;
                        clrIdx_q <= '0;
                    end else begin
                        clrIdx_q <= clrIdx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NR_KEY; g++) begin : g_lut
        assign o_lut[g*ENT_W +: ENT_W] = {key_q[g], data_q[g]};
    end

    assign o_vld_mask = vld_q;
    assign o_count    = count_q;
    assign o_wr_done  = wrDone_q;
    assign o_wr_err   = wrErr_q;
    assign o_rd_valid = rdValid_q;
    assign o_rd_hit   = rdHit_q;
    assign o_rd_data  = rdData_q;

endmodule

// File: doc/stl_lut_table.md
STL_LUT_TABLE -- requirements
Module: stl_lut_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 2, number of table entries (>=2).
REQ-002 SHALL have parameter KEY_LEN, default 1, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 1, data width in bits.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports i_wr_valid input 1, i_wr_key input KEY_LEN and i_wr_data input DATA_LEN, forming the write request.
REQ-007 SHALL have port o_wr_ready  output  1  write request may be accepted this cycle.
REQ-008 SHALL have ports o_wr_done output 1 and o_wr_err output 1, forming the write response pulse and the table-full flag.
REQ-009 SHALL have port i_clr  input  1  clear-all request, one-cycle pulse.
REQ-010 SHALL have ports i_rd_valid input 1 and i_rd_key input KEY_LEN, forming the lookup request.
REQ-011 SHALL have ports o_rd_valid output 1, o_rd_hit output 1 and o_rd_data output DATA_LEN, forming the lookup response.
REQ-012 SHALL have port o_lut  output  NR_KEY*(KEY_LEN+DATA_LEN)  packed table, directly consumable as a key/data LUT bus.
REQ-013 SHALL have port o_vld_mask  output  NR_KEY  per-entry valid bits.
REQ-014 SHALL have port o_count  output  $clog2(NR_KEY+1)  number of valid entries.

Function
REQ-015 SHALL place entry i in o_lut[(i+1)*(KEY_LEN+DATA_LEN)-1 : i*(KEY_LEN+DATA_LEN)], with the key in the upper KEY_LEN bits and the data in the lower DATA_LEN bits.
REQ-016 SHALL implement FSM states IDLE and CLR, transitioning IDLE->CLR when i_clr is high in IDLE.
REQ-017 SHALL drive o_wr_ready = (state==IDLE) && !i_clr, combinationally.
REQ-018 SHALL accept a write on any cycle where i_wr_valid && o_wr_ready.
REQ-019 SHALL, on an accepted write whose key matches a valid entry, overwrite that entry's data, leave o_count unchanged, and set o_wr_err=0.
REQ-020 SHALL, on an accepted write with no match and not full, store {key,data} in the lowest-index invalid entry, set its valid bit, increment o_count, and set o_wr_err=0.
REQ-021 SHALL, on an accepted write with no match and o_count==NR_KEY, leave the table unchanged and set o_wr_err=1.
REQ-022 SHALL pulse o_wr_done high for exactly one cycle, the cycle after acceptance; o_wr_err is valid only while o_wr_done=1 and is 0 otherwise.
REQ-023 SHALL never hold more than one valid entry with the same key.
REQ-024 SHALL, in CLR, clear one entry per cycle (key, data and valid bit set to 0) via an index counter running 0..NR_KEY-1, decrementing o_count once per cleared entry that was valid.
REQ-025 SHALL return from CLR to IDLE after clearing entry NR_KEY-1, so that o_wr_ready is low for exactly NR_KEY cycles starting the cycle after i_clr.
REQ-026 SHALL ignore i_clr while in CLR.
REQ-027 SHALL give a clear in the same cycle as i_wr_valid priority: the write is not accepted.
REQ-028 SHALL register lookups with fixed latency 1: o_rd_valid is i_rd_valid delayed one cycle, with no backpressure.
REQ-029 SHALL evaluate a lookup against table contents before any same-cycle write, i.e. it sees old data.
REQ-030 SHALL, on a lookup hit, drive o_rd_hit=1 and o_rd_data equal to the matching entry's data.
REQ-031 SHALL, on a lookup miss, a lookup issued in CLR state, or when o_rd_valid=0, drive o_rd_hit=0 and o_rd_data=0.
REQ-032 SHALL compare only valid entries; invalid entries whose key field is 0 never match key 0.

Reset
REQ-033 SHALL, while i_rst is high at a clock edge, set state=IDLE, clear all entries to 0, and set o_vld_mask=0, o_count=0, o_wr_done=0, o_wr_err=0, o_rd_valid=0, o_rd_hit=0, o_rd_data=0.
REQ-034 SHALL abort an in-progress CLR walk on reset and return to IDLE with an empty table.
REQ-035 SHALL take reset priority over i_clr, writes and lookups.

Verification (NR_KEY=4, KEY_LEN=3, DATA_LEN=8)
REQ-036 SHALL be covered by: write (3,0xA5), then lookup key 3 -> o_wr_done=1, o_wr_err=0, o_count=1, o_vld_mask=4'b0001; next cycle o_rd_hit=1, o_rd_data=0xA5.
REQ-037 SHALL be covered by: write keys 0,1,2,3, then write (5,0x11) -> fifth o_wr_done has o_wr_err=1, o_count=4, and key 5 lookup misses.
REQ-038 SHALL be covered by: write (2,0x10), then write (2,0x20) -> o_count=1, lookup key 2 returns 0x20, and o_lut entry0 equals {3'd2,8'h20}.
REQ-039 SHALL be covered by: lookup key 0 on an empty table -> o_rd_hit=0, o_rd_data=0.
REQ-040 SHALL be covered by: fill 3 entries, pulse i_clr together with i_wr_valid -> write not accepted, o_wr_ready low for 4 cycles, o_count then 0, and lookups in CLR return hit=0.
REQ-041 SHALL be covered by: write (1,0x33) and lookup key 1 in the same cycle -> o_rd_hit=0; repeating the lookup next cycle -> o_rd_hit=1, o_rd_data=0x33; asserting i_rst mid-CLR -> IDLE with o_count=0 on the next cycle.
